mem_port_adapter: RTL

// - Sits between the multicycle RV32I datapath/control (mem_read/mem_write held until mem_resp) and physical memory.
// - Steers sub-word store data into byte lanes and generates byte enables.
// - Extracts and sign/zero-extends sub-word load data.
// - Rejects misaligned accesses and bounds memory latency with a timeout.

---
 rtl/mem_port_adapter_pkg.sv | 12 +
 rtl/mem_port_adapter_if.sv | 33 +++
 rtl/mem_port_adapter_align.sv | 55 +++++
 rtl/mem_port_adapter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_port_adapter_pkg.sv
// Shared types for the RV32I memory port adapter.
package mem_port_adapter_pkg;

    typedef enum logic [1:0] {
        mem_b = 2'b00,
        mem_h = 2'b01,
        mem_w = 2'b10
    } mem_size_t;

    localparam logic [1:0] MEM_SIZE_BAD = 2'b11;

endpackage

// File: rtl/mem_port_adapter_if.sv
// CPU-side request/response and physical-memory bus seen by the adapter.
interface mem_port_adapter_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        mem_error;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [31:0] pmem_rdata;

    // master = CPU control plus physical memory; slave = the adapter between them
    modport master (
        output mem_read, mem_write, mem_address, mem_funct3, mem_wdata,
        input  mem_rdata, mem_resp, mem_error,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        output pmem_resp, pmem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_funct3, mem_wdata,
        output mem_rdata, mem_resp, mem_error,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        input  pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/mem_port_adapter_align.sv
// Combinational lane logic: byte enables, store steering, load extraction
// and extension, misalignment and size checks.
module mem_port_adapter_align
    import mem_port_adapter_pkg::*;
#(
    parameter int ERR_MISALIGN = 1
) (
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_bad_size
);
    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic [4:0]  w_shamt;
    logic [31:0] w_lane;

    always_comb begin
        w_size     = i_funct3[1:0];
        o_bad_size = (w_size == MEM_SIZE_BAD);
        case (w_size)
            mem_h:   o_misalign = i_off[0];
            mem_w:   o_misalign = |i_off;
            default: o_misalign = 1'b0;
        endcase
        // When misalignment is tolerated, the access collapses onto lane 0.
        w_off   = (o_misalign && (ERR_MISALIGN == 0)) ? 2'b00 : i_off;
        w_shamt = {w_off, 3'b000};
        o_wdata = i_wdata << w_shamt;
        w_lane  = i_rdata >> w_shamt;
        case (w_size)
            mem_b: begin
                o_be    = 4'b0001 << w_off;
                o_rdata = i_funct3[2] ? {24'd0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
            end
            mem_h: begin
                o_be    = 4'b0011 << w_off;
                o_rdata = i_funct3[2] ? {16'd0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
            end
            mem_w: begin
                o_be    = 4'b1111;
                o_rdata = i_rdata;
            end
            default: begin
                o_be    = 4'b0000;
                o_rdata = 32'd0;
            end
        endcase
    end
endmodule

// File: rtl/mem_port_adapter.sv
// Multicycle CPU memory port to physical memory adapter with sub-word
// steering, misalignment rejection and a bounded-latency timeout.
module mem_port_adapter
    import mem_port_adapter_pkg::*;
#(
    parameter int TIMEOUT      = 255,
    parameter int ERR_MISALIGN = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_adapter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_HOLD} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [29:0]   r_waddr;
    logic [1:0]    r_off;
    logic [2:0]    r_funct3;
    logic          r_is_read;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_req, w_illegal, w_last;
    logic [1:0]    w_off;
    logic [2:0]    w_funct3;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_rdata;
    logic          w_misalign, w_bad_size;

    // Live inputs drive the lane logic only while IDLE; afterwards the latched copy does.
    assign w_off    = (r_state == S_IDLE) ? bus.mem_address[1:0] : r_off;
    assign w_funct3 = (r_state == S_IDLE) ? bus.mem_funct3 : r_funct3;
    assign w_req    = bus.mem_read | bus.mem_write;
    assign w_illegal = (bus.mem_read & bus.mem_write) | w_bad_size
                     | (w_misalign & (ERR_MISALIGN != 0));
    assign w_last   = (r_cnt == CW'(TIMEOUT - 1));

    mem_port_adapter_align #(.ERR_MISALIGN(ERR_MISALIGN)) u_align (
        .i_off      (w_off),
        .i_funct3   (w_funct3),
        .i_wdata    (bus.mem_wdata),
        .i_rdata    (bus.pmem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign),
        .o_bad_size (w_bad_size)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_req) w_next = w_illegal ? S_RESP : S_ACCESS;
            S_ACCESS: if (bus.pmem_resp || w_last) w_next = S_RESP;
            S_RESP:   w_next = S_HOLD;
            S_HOLD:   if (!w_req) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.pmem_read        = (r_state == S_ACCESS) &  r_is_read;
        bus.pmem_write       = (r_state == S_ACCESS) & ~r_is_read;
        bus.pmem_address     = {r_waddr, 2'b00};
        bus.pmem_wdata       = r_wdata;
        bus.pmem_byte_enable = r_be;
        bus.mem_resp         = (r_state == S_RESP);
        bus.mem_error        = r_err;
        bus.mem_rdata        = r_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_waddr   <= '0;
            r_off     <= '0;
            r_funct3  <= '0;
            r_is_read <= 1'b0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_cnt     <= '0;
                    r_waddr   <= bus.mem_address[31:2];
                    r_off     <= bus.mem_address[1:0];
                    r_funct3  <= bus.mem_funct3;
                    r_is_read <= bus.mem_read;
                    r_wdata   <= w_wdata;
                    r_be      <= w_be;
                    r_rdata   <= '0;
                    r_err     <= w_illegal;
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (bus.pmem_resp) begin
                        r_rdata <= r_is_read ? w_rdata : 32'd0;
                        r_err   <= 1'b0;
                    end else if (w_last) begin
                        r_rdata <= 32'd0;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
